// File: rtl/mctrl_pkg.sv
// Shared encodings for the multicycle RV32 control FSM.
// State codes, opcodes, ALU operand/op selects and the control word.
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_TRAP   = 4'd9
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       trap;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mctrl_out_decode.sv
// State (+mem_ready, zero) to control word decoder.
// trap is only asserted when built with MCTRL_TRAP_EN.
module mctrl_out_decode
  import mctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  input  logic   i_zero,
  output ctrl_t  o_ctrl
);

  logic w_pc_write;
  logic w_pc_write_cond;

  always_comb begin
    o_ctrl          = '0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    unique case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.ir_write  = i_mem_ready;
        w_pc_write       = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_BOFF;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RS2;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: o_ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RS2;
        o_ctrl.alu_op    = ALU_SUB;
        o_ctrl.pc_source = 1'b1;
        w_pc_write_cond  = 1'b1;
      end
`ifdef MCTRL_TRAP_EN
      S_TRAP: o_ctrl.trap = 1'b1;
`endif
      default: o_ctrl = '0;
    endcase
    o_ctrl.pc_en = w_pc_write | (w_pc_write_cond & i_zero);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 main control FSM with retired-instruction counter.
// Define MCTRL_TRAP_EN to trap illegal opcodes until trap_ack.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int RET_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  input  logic                 trap_ack,
  output logic                 pc_en,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 pc_source,
  output logic                 instr_retired,
  output logic [RET_CNT_W-1:0] retire_cnt,
  output logic                 trap
);

  state_t                r_state;
  state_t                w_next;
  ctrl_t                 w_ctrl;
  logic                  w_retire;
  logic                  r_retired;
  logic [RET_CNT_W-1:0]  r_retire_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (is_mem_op(opcode))    w_next = S_MEMADR;
        else if (opcode == OP_RTYPE) w_next = S_EXEC;
        else if (opcode == OP_BEQ)   w_next = S_BRANCH;
`ifdef MCTRL_TRAP_EN
        else                         w_next = S_TRAP;
`else
        else                         w_next = S_FETCH;
`endif
      end
      S_MEMADR: w_next = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_EXEC:   w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
`ifdef MCTRL_TRAP_EN
      S_TRAP:   if (trap_ack) w_next = S_FETCH;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

`ifndef MCTRL_TRAP_EN
  logic w_unused_trap_ack;
  assign w_unused_trap_ack = trap_ack;
`endif

  mctrl_out_decode u_dec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_zero      (zero),
    .o_ctrl      (w_ctrl)
  );

  always_comb begin
    w_retire = 1'b0;
    unique case (r_state)
      S_MEMWB, S_RWB, S_BRANCH: w_retire = 1'b1;
      S_MEMWR:                  w_retire = mem_ready;
      default:                  w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired    <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      r_retired    <= w_retire;
      r_retire_cnt <= r_retire_cnt
                    + {{(RET_CNT_W-1){1'b0}}, w_retire};
    end
  end

  // Write/load strobes are gated so a mid-op reset never commits anything.
  always_comb begin
    pc_en         = w_ctrl.pc_en & rst_n;
    ir_write      = w_ctrl.ir_write & rst_n;
    reg_write     = w_ctrl.reg_write & rst_n;
    mem_write     = w_ctrl.mem_write & rst_n;
    mem_read      = w_ctrl.mem_read & rst_n;
    i_or_d        = w_ctrl.i_or_d;
    mem_to_reg    = w_ctrl.mem_to_reg;
    alu_src_a     = w_ctrl.alu_src_a;
    alu_src_b     = w_ctrl.alu_src_b;
    alu_op        = w_ctrl.alu_op;
    pc_source     = w_ctrl.pc_source;
    trap          = w_ctrl.trap;
    instr_retired = r_retired;
    retire_cnt    = r_retire_cnt;
  end

endmodule
